// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use / mult-div stalls, branch flush and pipeline-register enables.
module hazard_controller #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] id_dest,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_md_start,
  input  logic       id_use_hilo,
  input  logic       branch_taken,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } ex_stage_t;

  ex_stage_t        ex_q;
  ex_stage_t        ex_d;
  logic [REG_W-1:0] mem_dest;
  logic             mem_rw;
  logic [REG_W-1:0] wb_dest;
  logic             wb_rw;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_d;
  logic             load_use;
  logic             md_hazard;
  logic             stall;

  // $0 is hardwired, so it never produces a hazard or a forward.
  function automatic logic reg_match(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src);
    return (dest != '0) && (dest == src);
  endfunction

  // Youngest producer wins: MEM result before WB result.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             m_rw,
                                         input logic [REG_W-1:0] m_dest,
                                         input logic             w_rw,
                                         input logic [REG_W-1:0] w_dest);
    if (m_rw && reg_match(m_dest, src)) return 2'b10;
    if (w_rw && reg_match(w_dest, src)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    md_busy   = (md_cnt != '0);
    load_use  = ex_q.mr &
                ((reg_match(ex_q.dest, id_rs) & id_use_rs) |
                 (reg_match(ex_q.dest, id_rt) & id_use_rt));
    md_hazard = md_busy & id_use_hilo;
    stall     = load_use | md_hazard;

    pc_write_en   = ~stall;
    ifid_write_en = ~stall;
    idex_bubble   = stall;
    ifid_flush    = branch_taken & ~stall;

    fwd_a = fwd_sel(ex_q.rs, mem_rw, mem_dest, wb_rw, wb_dest);
    fwd_b = fwd_sel(ex_q.rt, mem_rw, mem_dest, wb_rw, wb_dest);

    ex_d = '0;
    if (!stall) begin
      ex_d.rs   = id_rs;
      ex_d.rt   = id_rt;
      ex_d.dest = id_dest;
      ex_d.rw   = id_reg_write;
      ex_d.mr   = id_mem_read;
    end

    md_cnt_d = md_cnt;
    if (id_md_start && !stall) md_cnt_d = CNT_W'(MD_LATENCY);
    else if (md_busy)          md_cnt_d = md_cnt - CNT_W'(1);
  end

  // Shadow pipeline advances every cycle; a stall inserts a bubble into EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_dest <= '0;
      mem_rw   <= 1'b0;
      wb_dest  <= '0;
      wb_rw    <= 1'b0;
      md_cnt   <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_dest <= ex_q.dest;
      mem_rw   <= ex_q.rw;
      wb_dest  <= mem_dest;
      wb_rw    <= mem_rw;
      md_cnt   <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed bench for hazard_controller against an
// instruction-history reference model.
module tb_hazard_controller;

  localparam int unsigned LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic       id_md_start, id_use_hilo, branch_taken;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble, md_busy;
  logic [1:0] fwd_a, fwd_b;

  hazard_controller #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_md_start(id_md_start), .id_use_hilo(id_use_hilo),
    .branch_taken(branch_taken),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs;
    int rt;
    int dest;
    bit rw;
    bit mr;
  } instr_t;

  // Model: list of instructions that entered EX (bubbles included), plus the
  // cycle number of the last accepted mult/div start.
  instr_t hist[$];
  int     now_cyc;
  int     md_start_cyc;

  int n_checks = 0;
  int n_pass   = 0;

  bit       obs_pc, obs_stall_seen, obs_flush, obs_busy;
  bit [1:0] obs_fa, obs_fb;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic instr_t stage(input int back);
    instr_t z;
    z = '{0, 0, 0, 1'b0, 1'b0};
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return z;
  endfunction

  function automatic bit hits(input int d, input int r);
    return d != 0 && d == r;
  endfunction

  function automatic int fwd_of(input int src);
    instr_t m, w;
    m = stage(1);
    w = stage(2);
    if (m.rw && hits(m.dest, src)) return 2;
    if (w.rw && hits(w.dest, src)) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    now_cyc = 0;
    md_start_cyc = -100;
  endfunction

  // One pipeline cycle: drive ID, compare every output with the model, advance.
  task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                      input int dest, input bit rw, input bit mr, input bit mds,
                      input bit hilo, input bit br, input bit rst);
    instr_t ex, nxt;
    bit lu, busy, stl;
    @(negedge clk);
    reset = rst;
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr;
    id_md_start = mds; id_use_hilo = hilo; branch_taken = br;
    #1;
    ex   = stage(0);
    lu   = ex.mr && ((hits(ex.dest, rs) && urs) || (hits(ex.dest, rt) && urt));
    busy = (now_cyc - md_start_cyc >= 1) && (now_cyc - md_start_cyc <= int'(LAT));
    stl  = lu || (busy && hilo);
    check("pc_write_en",   int'(pc_write_en),   int'(!stl));
    check("ifid_write_en", int'(ifid_write_en), int'(!stl));
    check("idex_bubble",   int'(idex_bubble),   int'(stl));
    check("ifid_flush",    int'(ifid_flush),    int'(br && !stl));
    check("fwd_a",         int'(fwd_a),         fwd_of(ex.rs));
    check("fwd_b",         int'(fwd_b),         fwd_of(ex.rt));
    check("md_busy",       int'(md_busy),       int'(busy));
    obs_pc = pc_write_en; obs_stall_seen = idex_bubble; obs_flush = ifid_flush;
    obs_busy = md_busy; obs_fa = fwd_a; obs_fb = fwd_b;
    if (rst) begin
      model_reset();
    end else begin
      nxt = stl ? '{0, 0, 0, 1'b0, 1'b0} : '{rs, rt, dest, rw, mr};
      hist.push_back(nxt);
      if (hist.size() > 4) void'(hist.pop_front());
      if (mds && !stl) md_start_cyc = now_cyc;
      now_cyc++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int stall_cnt;
  bit released;

  initial begin
    reset = 1'b1;
    id_rs = '0; id_rt = '0; id_dest = '0; id_use_rs = 0; id_use_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_md_start = 0; id_use_hilo = 0;
    branch_taken = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset values with all inputs low
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_pc", int'(obs_pc), 1);
    check("rst_fwd_a", int'(obs_fa), 0);
    check("rst_busy", int'(obs_busy), 0);

    // Back-to-back dependency: EX/MEM forward
    step(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    step(5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    idle();
    check("b2b_fwd_a", int'(obs_fa), 2);
    // One independent op in between: MEM/WB forward
    step(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    step(3, 4, 1, 1, 7, 1, 0, 0, 0, 0, 0);
    step(5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    idle();
    check("gap_fwd_a", int'(obs_fa), 1);

    // Load-use: one bubble, then WB forward
    step(1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
    step(2, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0);
    check("lu_stall_pc", int'(obs_pc), 0);
    check("lu_stall_bubble", int'(obs_stall_seen), 1);
    step(2, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0);
    check("lu_release_pc", int'(obs_pc), 1);
    idle();
    check("lu_fwd_b", int'(obs_fb), 1);

    // Register 0 never hazards
    step(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    check("r0_pc", int'(obs_pc), 1);
    idle();
    check("r0_fwd_a", int'(obs_fa), 0);

    // mult followed by mfhi: stall for LAT cycles
    step(4, 5, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    stall_cnt = 0;
    released = 0;
    for (int i = 0; i < 12 && !released; i++) begin
      step(0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0);
      if (obs_stall_seen) stall_cnt++;
      else begin
        released = 1;
        check("md_busy_at_release", int'(obs_busy), 0);
      end
    end
    check("md_released", int'(released), 1);
    check("md_stall_cycles", stall_cnt, int'(LAT));

    // Branch during a load-use stall is ignored, then honoured
    step(1, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0);
    step(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("br_in_stall", int'(obs_flush), 0);
    step(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("br_after_stall", int'(obs_flush), 1);

    // Reset in the middle of a mult/div
    step(4, 5, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    check("rst_mid_md", int'(obs_busy), 0);

    // Randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 3000; i++) begin
      bit mds, hilo;
      mds  = ($urandom_range(0, 15) == 0);
      hilo = mds || ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), mds, hilo,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
